// File: rtl/min_tracker_pkg.sv
// Shared types and helpers for the running-extremum tracker.
package min_tracker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_DATA_WIDTH = 64;

    // Starting value that any real sample can beat: all-ones for min, zero for max.
    function automatic logic [MAX_DATA_WIDTH-1:0] init_value(input int width, input bit mode_max);
        logic [MAX_DATA_WIDTH-1:0] ones;
        ones = '1;
        if (mode_max)
            return '0;
        return ones >> (MAX_DATA_WIDTH - width);
    endfunction

endpackage

// File: rtl/min_tracker_if.sv
// Sample stream in, framed result out; master is the controller side.
interface min_tracker_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 16
) ();
    logic                   Start;
    logic                   InValid;
    logic [DATA_WIDTH-1:0]  DataIn;
    logic [INDEX_WIDTH-1:0] IndexIn;
    logic                   Last;
    logic                   Ack;
    logic                   Ready;
    logic                   Busy;
    logic                   Done;
    logic                   ResultValid;
    logic [DATA_WIDTH-1:0]  MinValue;
    logic [INDEX_WIDTH-1:0] MinIndex;
    logic [INDEX_WIDTH-1:0] Count;

    modport master (
        output Start, InValid, DataIn, IndexIn, Last, Ack,
        input  Ready, Busy, Done, ResultValid, MinValue, MinIndex, Count
    );

    modport slave (
        input  Start, InValid, DataIn, IndexIn, Last, Ack,
        output Ready, Busy, Done, ResultValid, MinValue, MinIndex, Count
    );
endinterface

// File: rtl/min_tracker_extremum_cmp.sv
// Combinational "is a better than the current extremum b" test, unsigned.
module min_tracker_extremum_cmp #(
    parameter int DATA_WIDTH = 32,
    parameter bit MODE_MAX   = 1'b0,
    parameter bit TIE_LATEST = 1'b0
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  better
);
    always_comb begin
        if (MODE_MAX)
            better = TIE_LATEST ? (a >= b) : (a > b);
        else
            better = TIE_LATEST ? (a <= b) : (a < b);
    end
endmodule

// File: rtl/min_tracker.sv
// Running min/max over a Start/Last framed sample stream with held result.
module min_tracker
    import min_tracker_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 16,
    parameter bit MODE_MAX    = 1'b0,
    parameter bit TIE_LATEST  = 1'b0
) (
    input  logic           Clk,
    input  logic           Reset,
    min_tracker_if.slave   bus
);
    localparam logic [DATA_WIDTH-1:0] INIT = DATA_WIDTH'(init_value(DATA_WIDTH, MODE_MAX));

    state_t state;
    logic   better;

    min_tracker_extremum_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .MODE_MAX   (MODE_MAX),
        .TIE_LATEST (TIE_LATEST)
    ) u_cmp (
        .a      (bus.DataIn),
        .b      (bus.MinValue),
        .better (better)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state           <= IDLE;
            bus.MinValue    <= INIT;
            bus.MinIndex    <= '0;
            bus.Count       <= '0;
            bus.Ready       <= 1'b0;
            bus.Busy        <= 1'b0;
            bus.Done        <= 1'b0;
            bus.ResultValid <= 1'b0;
        end else begin
            bus.Done <= 1'b0;
            // Start from any state opens a fresh frame; it also beats Ack in DONE
            // and drops a sample offered in the same cycle.
            if (bus.Start) begin
                state           <= RUN;
                bus.MinValue    <= INIT;
                bus.MinIndex    <= '0;
                bus.Count       <= '0;
                bus.ResultValid <= 1'b0;
                bus.Ready       <= 1'b1;
                bus.Busy        <= 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        if (bus.InValid) begin
                            if (bus.Count != '1)
                                bus.Count <= bus.Count + 1'b1;
                            if (better) begin
                                bus.MinValue <= bus.DataIn;
                                bus.MinIndex <= bus.IndexIn;
                            end
                            if (bus.Last) begin
                                state           <= DONE;
                                bus.Ready       <= 1'b0;
                                bus.Busy        <= 1'b0;
                                bus.Done        <= 1'b1;
                                bus.ResultValid <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        if (bus.Ack)
                            state <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_min_tracker.sv
// Scoreboard bench: four tracker flavours sharing one stimulus bus, gated per test.
module tb_min_tracker;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start, inv, last, ack;
    logic [31:0] din;
    logic [15:0] iin;
    logic [3:0]  en;

    int pass_cnt = 0;
    int total    = 0;

    typedef struct {
        logic [31:0] v;
        logic [15:0] i;
        logic [15:0] c;
    } exp_t;

    exp_t q0[$], q1[$], q2[$], q3[$];

    min_tracker_if #(.DATA_WIDTH(32), .INDEX_WIDTH(16)) if0 ();
    min_tracker_if #(.DATA_WIDTH(32), .INDEX_WIDTH(16)) if1 ();
    min_tracker_if #(.DATA_WIDTH(32), .INDEX_WIDTH(16)) if2 ();
    min_tracker_if #(.DATA_WIDTH(8),  .INDEX_WIDTH(16)) if3 ();

    assign if0.Start = start & en[0];  assign if0.InValid = inv & en[0];
    assign if0.Last  = last & en[0];   assign if0.Ack     = ack & en[0];
    assign if0.DataIn = din;           assign if0.IndexIn = iin;
    assign if1.Start = start & en[1];  assign if1.InValid = inv & en[1];
    assign if1.Last  = last & en[1];   assign if1.Ack     = ack & en[1];
    assign if1.DataIn = din;           assign if1.IndexIn = iin;
    assign if2.Start = start & en[2];  assign if2.InValid = inv & en[2];
    assign if2.Last  = last & en[2];   assign if2.Ack     = ack & en[2];
    assign if2.DataIn = din;           assign if2.IndexIn = iin;
    assign if3.Start = start & en[3];  assign if3.InValid = inv & en[3];
    assign if3.Last  = last & en[3];   assign if3.Ack     = ack & en[3];
    assign if3.DataIn = din[7:0];      assign if3.IndexIn = iin;

    min_tracker #(.DATA_WIDTH(32), .INDEX_WIDTH(16), .MODE_MAX(1'b0), .TIE_LATEST(1'b0))
        u0 (.Clk(clk), .Reset(rst), .bus(if0));
    min_tracker #(.DATA_WIDTH(32), .INDEX_WIDTH(16), .MODE_MAX(1'b0), .TIE_LATEST(1'b1))
        u1 (.Clk(clk), .Reset(rst), .bus(if1));
    min_tracker #(.DATA_WIDTH(32), .INDEX_WIDTH(16), .MODE_MAX(1'b1), .TIE_LATEST(1'b0))
        u2 (.Clk(clk), .Reset(rst), .bus(if2));
    min_tracker #(.DATA_WIDTH(8),  .INDEX_WIDTH(16), .MODE_MAX(1'b0), .TIE_LATEST(1'b0))
        u3 (.Clk(clk), .Reset(rst), .bus(if3));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic mon(input int k, input logic [31:0] v, input logic [15:0] i, input logic [15:0] c);
        exp_t e;
        bit   have;
        have = 1'b0;
        case (k)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            2: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            total++;
            $display("FAIL dut%0d unexpected Done: value %0h index %0h count %0h", k, v, i, c);
        end else begin
            chk($sformatf("dut%0d result value", k), v, e.v);
            chk($sformatf("dut%0d result index", k), 32'(i), 32'(e.i));
            chk($sformatf("dut%0d result count", k), 32'(c), 32'(e.c));
        end
    endtask

    // Monitor: every Done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (if0.Done) mon(0, if0.MinValue, if0.MinIndex, if0.Count);
        if (if1.Done) mon(1, if1.MinValue, if1.MinIndex, if1.Count);
        if (if2.Done) mon(2, if2.MinValue, if2.MinIndex, if2.Count);
        if (if3.Done) mon(3, 32'(if3.MinValue), if3.MinIndex, if3.Count);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1; cyc(); ack = 1'b0;
    endtask

    task automatic sample(input logic [31:0] v, input logic [15:0] i, input logic l);
        inv = 1'b1; din = v; iin = i; last = l;
        cyc();
        inv = 1'b0; last = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; inv = 1'b0; last = 1'b0; ack = 1'b0;
        din = '0; iin = '0; en = 4'hF;
        cyc(); cyc();
        chk("reset u0 value", if0.MinValue, 32'hFFFF_FFFF);
        chk("reset u2 value (max INIT)", if2.MinValue, 32'h0);
        chk("reset u3 value (8-bit INIT)", 32'(if3.MinValue), 32'hFF);
        chk("reset u0 count", 32'(if0.Count), 0);
        chk("reset u0 busy/ready/done/rv", {28'h0, if0.Busy, if0.Ready, if0.Done, if0.ResultValid}, 0);
        rst = 1'b0;

        // Reset in the middle of a frame
        en = 4'b0001;
        do_start();
        sample(32'd5, 16'd0, 1'b0); sample(32'd6, 16'd1, 1'b0); sample(32'd7, 16'd2, 1'b0);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("midrun reset value", if0.MinValue, 32'hFFFF_FFFF);
        chk("midrun reset index", 32'(if0.MinIndex), 0);
        chk("midrun reset count", 32'(if0.Count), 0);
        chk("midrun reset rv/busy", {30'h0, if0.ResultValid, if0.Busy}, 0);

        // Min mode, tie-earliest vs tie-latest
        en = 4'b0011;
        q0.push_back('{v: 32'd20, i: 16'd1, c: 16'd4});
        q1.push_back('{v: 32'd20, i: 16'd3, c: 16'd4});
        do_start();
        chk("start clears rv", 32'(if0.ResultValid), 0);
        sample(32'd50, 16'd0, 1'b0);
        chk("first sample latency", if0.MinValue, 32'd50);
        sample(32'd20, 16'd1, 1'b0);
        chk("update index", 32'(if0.MinIndex), 1);
        sample(32'd35, 16'd2, 1'b0);
        sample(32'd20, 16'd3, 1'b1);
        cyc();
        chk("done state busy", 32'(if0.Busy), 0);
        chk("done state rv", 32'(if0.ResultValid), 1);
        do_ack();
        chk("ack hold value", if0.MinValue, 32'd20);
        chk("ack hold rv", 32'(if1.ResultValid), 1);

        // Max mode then Ack
        en = 4'b0100;
        q2.push_back('{v: 32'd9, i: 16'd1, c: 16'd3});
        do_start();
        sample(32'd7, 16'd0, 1'b0); sample(32'd9, 16'd1, 1'b0); sample(32'd3, 16'd2, 1'b1);
        do_ack();
        chk("max after ack value", if2.MinValue, 32'd9);
        chk("max after ack index", 32'(if2.MinIndex), 1);
        chk("max after ack rv", 32'(if2.ResultValid), 1);
        chk("max after ack ready", 32'(if2.Ready), 0);

        // InValid gaps
        en = 4'b0001;
        q0.push_back('{v: 32'd25, i: 16'd2, c: 16'd3});
        do_start();
        sample(32'd30, 16'd0, 1'b0);
        din = 32'd1; iin = 16'd9; cyc(); cyc();
        chk("gap value", if0.MinValue, 32'd30);
        chk("gap count", 32'(if0.Count), 1);
        sample(32'd40, 16'd1, 1'b0);
        sample(32'd25, 16'd2, 1'b1);
        sample(32'd3, 16'd7, 1'b0);
        chk("done frozen value", if0.MinValue, 32'd25);
        chk("done frozen count", 32'(if0.Count), 3);

        // Start from DONE, restart mid-run, Start+Ack together
        q0.push_back('{v: 32'd40, i: 16'd0, c: 16'd1});
        q0.push_back('{v: 32'd60, i: 16'd5, c: 16'd1});
        do_start();
        chk("b2b start rv", 32'(if0.ResultValid), 0);
        chk("b2b start busy", 32'(if0.Busy), 1);
        sample(32'd10, 16'd0, 1'b0); sample(32'd5, 16'd1, 1'b0);
        start = 1'b1; inv = 1'b1; din = 32'd1; iin = 16'd7;
        cyc();
        start = 1'b0; inv = 1'b0;
        chk("restart discards sample count", 32'(if0.Count), 0);
        chk("restart discards sample value", if0.MinValue, 32'hFFFF_FFFF);
        sample(32'd40, 16'd0, 1'b1);
        start = 1'b1; ack = 1'b1; cyc(); start = 1'b0; ack = 1'b0;
        chk("start beats ack busy", 32'(if0.Busy), 1);
        chk("start beats ack rv", 32'(if0.ResultValid), 0);
        sample(32'd60, 16'd5, 1'b1);
        do_ack();

        // 8-bit boundary: all-ones sample never beats INIT, zero does
        en = 4'b1000;
        q3.push_back('{v: 32'hFF, i: 16'd0, c: 16'd1});
        q3.push_back('{v: 32'h00, i: 16'd4, c: 16'd1});
        do_start();
        sample(32'hFF, 16'd3, 1'b1);
        do_start();
        sample(32'h00, 16'd4, 1'b1);
        do_ack();

        cyc(); cyc(); cyc();
        chk("dut0 pending results", 32'(q0.size()), 0);
        chk("dut1 pending results", 32'(q1.size()), 0);
        chk("dut2 pending results", 32'(q2.size()), 0);
        chk("dut3 pending results", 32'(q3.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/min_tracker.md
Name: min_tracker

Overview:
- Parametrised running-extremum unit for the competition datapath.
- Accepts a stream of (value, index) samples framed by Start/Last.
- Tracks the minimum (or, by mode, the maximum) value and the index where it occurred, and counts the samples.
- Presents a held, valid result to the controller at frame end.

Parameters:
- DATA_WIDTH, 32, width of sample values and of the result value.
- INDEX_WIDTH, 16, width of sample index, result index and sample count.
- MODE_MAX, 0, 0 = track minimum; 1 = track maximum.
- TIE_LATEST, 0, 0 = on equal values keep the earlier index; 1 = take the later index.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  begin a new frame; clears the tracker.
- InValid  in  1  sample present on DataIn/IndexIn this cycle.
- DataIn  in  DATA_WIDTH  sample value, unsigned.
- IndexIn  in  INDEX_WIDTH  sample tag, e.g. block offset.
- Last  in  1  qualifies the final sample of the frame; ignored unless InValid=1.
- Ack  in  1  controller consumed the result.
- Ready  out  1  in RUN state: samples are accepted.
- Busy  out  1  frame in progress (RUN).
- Done  out  1  single-cycle pulse on entry to DONE.
- ResultValid  out  1  result registers hold a completed frame.
- MinValue  out  DATA_WIDTH  tracked extremum.
- MinIndex  out  INDEX_WIDTH  index of the tracked extremum.
- Count  out  INDEX_WIDTH  samples accepted in the current or last frame.

Behaviour:
- Reset (sync, high), applied at any time including mid-frame:
  - State = IDLE.
  - MinValue = INIT, where INIT is all-ones for min mode and zero for max mode.
  - MinIndex = 0, Count = 0, Ready = 0, Busy = 0, Done = 0, ResultValid = 0.
- FSM IDLE:
  - Start -> RUN; load MinValue = INIT, MinIndex = 0, Count = 0, ResultValid = 0.
  - InValid is ignored in IDLE.
- FSM RUN:
  - Ready = 1, Busy = 1.
  - Each cycle with InValid=1:
    - Count += 1, saturating at all-ones.
    - Compare DataIn against MinValue; update MinValue and MinIndex on the next edge if the sample is better.
  - "Better" definition:
    - Min mode: DataIn < MinValue; with TIE_LATEST=1, <= instead.
    - Max mode: DataIn > MinValue; with TIE_LATEST=1, >= instead.
  - Compare is unsigned, full DATA_WIDTH, with no truncation.
  - InValid & Last -> DONE, and that sample is still evaluated and counted.
  - Update latency is 1 cycle: the result reflecting sample N is visible the cycle after N is accepted.
- FSM DONE:
  - Done = 1 for the first cycle only.
  - ResultValid = 1; outputs are frozen and InValid is ignored.
  - Ack -> IDLE, keeping ResultValid and values until the next Start.
  - Start -> RUN directly and clears the tracker (back-to-back frames).
  - Ack and Start in the same cycle: Start wins.
- Start while in RUN: restart the frame. The tracker clears, and a sample presented in the same cycle is discarded.
- Frame with Start followed immediately by Last on the first sample: Count=1, and the result is that sample.
- An all-INIT sample in min mode with TIE_LATEST=0 does not update MinIndex; the result is INIT with index 0. The verifier must expect this.
- The Count saturation flag is not exported; Count stays at max.

Decomposition:
- Shared package holds:
  - State encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - The INIT-value function of DATA_WIDTH/MODE_MAX.
- One natural sub-module: extremum_cmp. It is combinational, takes a, b, MODE_MAX and TIE_LATEST, and outputs better.
  - It is reused by the future multi-channel reduction tree.
- FSM, count and result registers stay in min_tracker.

Test Plan:
- Reset mid-RUN after 3 samples -> next cycle: state IDLE, MinValue=32'hFFFFFFFF, MinIndex=0, Count=0, ResultValid=0.
- Min mode, samples (val,idx) = (50,0), (20,1), (35,2), (20,3, Last) -> Done pulse; MinValue=20, MinIndex=1, Count=4.
  - Same stimulus with TIE_LATEST=1 -> MinIndex=3.
- MODE_MAX=1, samples 7, 9, 3 with Last on the 3rd -> MinValue=9, MinIndex=1. Then Ack -> IDLE with the result held and ResultValid=1.
- InValid gaps: samples in cycles 1, 4, 5 (Last) with InValid low between -> Count=3; no update during gap cycles.
- Start in RUN after 2 samples (10, 5), then new frame 40 (Last) -> MinValue=40, Count=1. Start and Ack together in DONE -> enters RUN with ResultValid=0.
- Boundary: DATA_WIDTH=8, sample 8'hFF only (Last) -> MinValue=8'hFF, MinIndex=0, Count=1. Sample 8'h00 -> MinValue=0.
